serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/fa_bit.sv | 13 +
 rtl/serial_adder.sv | 115 +++++++++++
 tb/tb_serial_adder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state type and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder: the only arithmetic in the serial adder datapath.
module fa_bit (
  output logic sum,
  output logic carry,
  input  logic x,
  input  logic y,
  input  logic ci
);

  assign sum   = x ^ y ^ ci;
  assign carry = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands and a carry-in on start,
// then adds one bit per clock (LSB first) through a single full adder.
// {c_out, s} is updated once, on the last RUN cycle, and done pulses for one
// cycle. Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' port selecting
// a - b - c_in (c_out = 1 means no borrow).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             busy,
  output logic             done
);

  // Counter must be able to represent WIDTH itself.
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             fa_sum;
  logic             fa_carry;

  // Choose the B operand and initial carry captured on start (inverted for subtract).
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    b_load = b;
    c_load = c_in;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load = ~b;
      c_load = ~c_in;
    end
`endif
  end

  fa_bit u_fa (
    .sum   (fa_sum),
    .carry (fa_carry),
    .x     (a_sh[0]),
    .y     (b_sh[0]),
    .ci    (carry_q)
  );

  // The new sum bit enters at the MSB; after WIDTH shifts the LSB of the
  // result sits at bit 0.
  assign acc_next = (acc >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  // FSM and datapath registers; s/c_out only change on the final RUN cycle.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift registers are reset too, so every flop in this block
      // has a known value after reset.
      state   <= IDLE;
      cnt     <= '0;
      carry_q <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      s       <= '0;
      c_out   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b_load;
            carry_q <= c_load;
            cnt     <= '0;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry_q <= fa_carry;
          acc     <= acc_next;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            s     <= acc_next;
            c_out <= fa_carry;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: a behavioural model (sum computed
// arithmetically, result released WIDTH edges after start) is compared with
// the WIDTH=8 instance every cycle; directed literal cases pin the model;
// a WIDTH=1 instance covers the single-bit corner.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       sub8;
  logic [7:0] s8;
  logic       cout8, busy8, done8;

  logic       start1;
  logic [0:0] a1, b1;
  logic       cin1;
  logic [0:0] s1;
  logic       cout1, busy1, done1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .c_in  (cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub8),
`endif
    .s     (s8),
    .c_out (cout8),
    .busy  (busy8),
    .done  (done8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .c_in  (cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (1'b0),
`endif
    .s     (s1),
    .c_out (cout1),
    .busy  (busy1),
    .done  (done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected {c_out, s} from plain arithmetic.
  function automatic logic [8:0] expect_op(input logic [7:0] x, input logic [7:0] y,
                                           input logic ci, input logic sb);
    int d;
    if (sb) begin
      d = int'(x) - int'(y) - int'(ci);
      return {(d >= 0) ? 1'b1 : 1'b0, d[7:0]};
    end
    return 9'(x) + 9'(y) + 9'(ci);
  endfunction

  // Behavioural model: an accepted request produces its result after 8 edges.
  int         m_left = 0;
  bit         m_done = 1'b0;
  logic [7:0] m_s    = '0;
  logic       m_cout = 1'b0;
  logic [8:0] m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_s    = '0;
      m_cout = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done          = 1'b1;
        {m_cout, m_s}   = m_pend;
      end
    end else begin
      m_done = 1'b0;
      if (start8) begin
        m_pend = expect_op(a8, b8, cin8, sub8);
        m_left = 8;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, busy8}, {31'd0, m_left > 0});
      check("done", {31'd0, done8}, {31'd0, m_done});
      check("s", {24'd0, s8}, {24'd0, m_s});
      check("c_out", {31'd0, cout8}, {31'd0, m_cout});
    end
  end

  // Issue one operation on the 8-bit DUT and wait (bounded) for done.
  // now=1 drives start in the current cycle (used when DUT sits in DONE).
  task automatic run8(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                      input logic xs, input bit now,
                      output logic [7:0] rs, output logic rc, output int lat, output int bc);
    if (!now) @(negedge clk);
    a8 = xa; b8 = xb; cin8 = xc; sub8 = xs; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    bc  = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bc++;
      @(negedge clk);
      lat++;
    end
    rs = s8;
    rc = cout8;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat, bc;
    logic [7:0] rs, ra, rb;
    logic       rc, rci, rsb;
    logic [8:0] ex;
    bit         now;

    rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_s", {24'd0, s8}, 32'h0);
    check("rst_cout", {31'd0, cout8}, 32'h0);
    check("rst_busy", {31'd0, busy8}, 32'h0);
    check("rst_done", {31'd0, done8}, 32'h0);
    rst = 1'b0;

    // Basic add and carry cases.
    run8(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, rs, rc, lat, bc);
    check("add_0f01_s", {24'd0, rs}, 32'h10);
    check("add_0f01_cout", {31'd0, rc}, 32'h0);
    check("add_0f01_latency", lat, 8);
    check("add_0f01_busy_cycles", bc, 8);
    run8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, rs, rc, lat, bc);
    check("add_ff01_s", {24'd0, rs}, 32'h00);
    check("add_ff01_cout", {31'd0, rc}, 32'h1);
    run8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, rs, rc, lat, bc);
    check("add_ffff1_s", {24'd0, rs}, 32'hFF);
    check("add_ffff1_cout", {31'd0, rc}, 32'h1);

    // Start pulsed mid-RUN is ignored.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'h55; b8 = 8'h66; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 4;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ignore_latency", lat, 8);
    check("ignore_s", {24'd0, s8}, 32'h46);
    check("ignore_cout", {31'd0, cout8}, 32'h0);

    // Back-to-back: start held in the DONE cycle.
    run8(8'h10, 8'h20, 1'b0, 1'b0, 1'b0, rs, rc, lat, bc);
    check("b2b_first_s", {24'd0, rs}, 32'h30);
    a8 = 8'h70; b8 = 8'h90; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      check("b2b_hold_s", {24'd0, s8}, 32'h30);
      @(negedge clk);
      lat++;
    end
    check("b2b_latency", lat, 8);
    check("b2b_s", {24'd0, s8}, 32'h00);
    check("b2b_cout", {31'd0, cout8}, 32'h1);

    // Reset during the 4th RUN cycle aborts with no done.
    run8(8'hA5, 8'h11, 1'b1, 1'b0, 1'b0, rs, rc, lat, bc);
    check("pre_rst_s", {24'd0, rs}, 32'hB7);
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy8}, 32'h0);
    check("abort_done", {31'd0, done8}, 32'h0);
    check("abort_s", {24'd0, s8}, 32'h0);
    check("abort_cout", {31'd0, cout8}, 32'h0);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, done8}, 32'h0);
    end

`ifdef SERIAL_ADDER_SUB_EN
    run8(8'h05, 8'h07, 1'b0, 1'b1, 1'b0, rs, rc, lat, bc);
    check("sub_0507_s", {24'd0, rs}, 32'hFE);
    check("sub_0507_cout", {31'd0, rc}, 32'h0);
    run8(8'h07, 8'h05, 1'b0, 1'b1, 1'b0, rs, rc, lat, bc);
    check("sub_0705_s", {24'd0, rs}, 32'h02);
    check("sub_0705_cout", {31'd0, rc}, 32'h1);
`endif

    // Randomized operations, some issued back-to-back from DONE.
    for (int i = 0; i < 150; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rci = 1'($urandom_range(0, 1));
      rsb = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      rsb = 1'($urandom_range(0, 1));
`endif
      now = bit'($urandom_range(0, 1));
      if (i == 0) now = 1'b0;
      run8(ra, rb, rci, rsb, now, rs, rc, lat, bc);
      ex = expect_op(ra, rb, rci, rsb);
      check("rand_result", {23'd0, rc, rs}, {23'd0, ex});
      check("rand_latency", lat, 8);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // WIDTH=1: every combination, done one edge after start.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a1 = 1'(k); b1 = 1'(k >> 1); cin1 = 1'(k >> 2); start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("w1_busy", {31'd0, busy1}, 32'h1);
      lat = 0;
      while (!done1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      check("w1_latency", lat, 1);
      check("w1_result", {30'd0, cout1, s1}, (k & 1) + ((k >> 1) & 1) + ((k >> 2) & 1));
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
